// File: rtl/alu_pkg.sv
// Shared ALU encodings, FSM state type and op-class helper.
// The ALU decoder and the execute-stage ALU both import this package.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/iter_shifter.sv
// One-bit-per-cycle shifter: load captures source/count/op, each step shifts once.
// next_val is the value after the current step; last flags the final step.
module iter_shifter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [SHW-1:0]  amt,
    output logic [XLEN-1:0] next_val,
    output logic            last
);

    logic [XLEN-1:0] shreg;
    logic [SHW-1:0]  cnt;
    logic [3:0]      op_q;

    always_comb begin
        next_val = shreg;
        case (op_q)
            ALU_SLL: next_val = {shreg[XLEN-2:0], 1'b0};
            ALU_SRL: next_val = {1'b0, shreg[XLEN-1:1]};
            ALU_SRA: next_val = {shreg[XLEN-1], shreg[XLEN-1:1]};
            default: next_val = shreg;
        endcase
    end

    assign last = (cnt == SHW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
            op_q  <= ALU_SLL;
        end else if (load) begin
            shreg <= a;
            cnt   <= amt;
            op_q  <= op;
        end else if (step) begin
            shreg <= next_val;
            cnt   <= cnt - SHW'(1);
        end
    end

endmodule

// File: rtl/iter_alu.sv
// Execute-stage ALU: single-cycle logic/arith ops, iterative shifts,
// valid/ready on both sides with a registered result and zero flag.
module iter_alu
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    state_t          state, state_next;
    logic            accept, load, step, last;
    logic [XLEN-1:0] op_result, shift_val;
    logic            op_illegal;

    iter_shifter #(.XLEN(XLEN), .SHW(SHW)) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .step     (step),
        .op       (alu_control),
        .a        (a),
        .amt      (b[SHW-1:0]),
        .next_val (shift_val),
        .last     (last)
    );

    // A shift by zero returns a unchanged, so it completes through the 1-cycle mux.
    always_comb begin
        op_result  = '0;
        op_illegal = 1'b0;
        case (alu_control)
            ALU_ADD: op_result = a + b;
            ALU_SUB: op_result = a - b;
            ALU_AND: op_result = a & b;
            ALU_OR:  op_result = a | b;
            ALU_XOR: op_result = a ^ b;
            ALU_SLT: op_result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLL, ALU_SRL, ALU_SRA: op_result = a;
            default: op_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        in_ready   = (state == ST_IDLE);
        out_valid  = (state == ST_DONE);
        accept     = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (is_shift(alu_control) && (b[SHW-1:0] != '0)) begin
                        load       = 1'b1;
                        state_next = ST_SHIFT;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                step = 1'b1;
                if (last) state_next = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
        end else if (accept && !load) begin
            result  <= op_result;
            zero    <= (op_result == '0);
            illegal <= op_illegal;
        end else if (step && last) begin
            result  <= shift_val;
            zero    <= (shift_val == '0);
            illegal <= 1'b0;
        end
    end

endmodule
